// File: rtl/module_grid_sampler.sv
// -----------------------------------------------------------------------------
// module_grid_sampler
//
// Purpose:
//   Walks a GRID x GRID lattice of QR module centres over the filtered binary
//   bitmap held in BRAM_one (1 bit/pixel, row-major, 2-cycle read latency).
//   It streams one sampled bit per module, row-major, to the decoder.
//   The lattice origin and pitch are latched on start_in. Positions are tracked
//   in 13-bit Q9.4 accumulators that saturate at 8191. A saturated
//   accumulator, or a pixel outside the image, yields a 0 sample and sets the
//   sticky error flag.
//
// Optional feature (macro SAMPLER_MAJORITY_EN):
//   Each module reads (px-1,py), (px,py) and (px+1,py). The neighbour x is
//   clamped to the image, and the bit is the 2-of-3 majority vote.
//   Without the macro, only the centre pixel is read.
//
// Ports:
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   start_in               1-cycle pulse in IDLE: latch origin/pitch, begin
//   origin_x_in/_y_in      top-left pixel of module (0,0)
//   pitch_in               module pitch, unsigned Q8.4 pixels/module
//   BRAM_one_address       registered read address
//   BRAM_one_data          read data for the address registered 2 edges ago
//   bit_out/bit_last_out   sampled bit / marks module GRID*GRID-1
//   bit_valid_out          bit offered to the consumer
//   bit_ready_in           consumer ready
//   busy_out               frame in progress
//   done_out               1-cycle pulse after the final bit is accepted
//   error_out              sticky out-of-image flag, cleared by start
//   dbg_state_o            current FSM state (debug)
//
// Handshake: a bit transfers on a rising edge where bit_valid_out and
// bit_ready_in are both high. Once valid is raised, bit_out and bit_last_out
// hold until that transfer. Valid never drops without a transfer.
// -----------------------------------------------------------------------------
module module_grid_sampler #(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 480,
    parameter int GRID   = 21,
    parameter int ADDR_W = 19
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [8:0]        origin_x_in,
    input  logic [8:0]        origin_y_in,
    input  logic [11:0]       pitch_in,
    output logic [ADDR_W-1:0] BRAM_one_address,
    input  logic              BRAM_one_data,
    output logic              bit_out,
    output logic              bit_valid_out,
    input  logic              bit_ready_in,
    output logic              bit_last_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [2:0]        dbg_state_o
);

    localparam int              CW       = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(GRID - 1);
    localparam logic [12:0]     ACC_SAT  = 13'h1FFF;
    localparam logic [9:0]      WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0]      HEIGHT_L = 10'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_ONE = 3'd2,
        S_WAIT_TWO = 3'd3,
        S_OUTPUT   = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       pitch_q;
    logic [12:0]       ax0_q, ax_q, ay_q;
    logic [CW-1:0]     row_q, col_q;
    logic [ADDR_W-1:0] addr_q;
    logic              oob_q, sample_q, error_q;

    // Saturating Q9.4 add. Once at 8191 the accumulator stays there.
    function automatic logic [12:0] sat_add(input logic [12:0] a, input logic [11:0] b);
        logic [13:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[13] ? ACC_SAT : s[12:0];
    endfunction

    logic [12:0] x_start, y_start;
    assign x_start = sat_add({origin_x_in, 4'b0000}, {1'b0, pitch_in[11:1]});
    assign y_start = sat_add({origin_y_in, 4'b0000}, {1'b0, pitch_in[11:1]});

    logic [8:0]        px, py, sx;
    logic              in_bounds, last_mod, taps_done;
    logic [ADDR_W-1:0] rd_addr;

    assign px        = ax_q[12:4];
    assign py        = ay_q[12:4];
    assign in_bounds = (ax_q != ACC_SAT) && (ay_q != ACC_SAT) &&
                       ({1'b0, px} < WIDTH_L) && ({1'b0, py} < HEIGHT_L);
    assign last_mod  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

`ifdef SAMPLER_MAJORITY_EN
    logic [1:0] tap_q;   // 0: left neighbour, 1: centre, 2: right neighbour
    logic [1:0] ones_q;  // ones seen in taps already captured

    // Neighbour x clamps to the image edge. It only matters when the centre is in bounds.
    always_comb begin
        sx = px;
        if (tap_q == 2'd0 && px != 9'd0) begin
            sx = px - 9'd1;
        end else if (tap_q == 2'd2 && {1'b0, px} != (WIDTH_L - 10'd1)) begin
            sx = px + 9'd1;
        end
    end
    assign taps_done = (tap_q == 2'd2);
`else
    assign sx        = px;
    assign taps_done = 1'b1;
`endif

    assign rd_addr = ADDR_W'(sx) + ADDR_W'(py) * ADDR_W'(WIDTH);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/status outputs
    always_comb begin
        state_d       = state_q;
        bit_valid_out = 1'b0;
        bit_last_out  = 1'b0;
        busy_out      = 1'b0;
        done_out      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_in) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy_out = 1'b1;
                state_d  = S_WAIT_ONE;
            end
            S_WAIT_ONE: begin
                busy_out = 1'b1;
                state_d  = S_WAIT_TWO;
            end
            S_WAIT_TWO: begin
                busy_out = 1'b1;
                state_d  = taps_done ? S_OUTPUT : S_ISSUE;
            end
            S_OUTPUT: begin
                busy_out      = 1'b1;
                bit_valid_out = 1'b1;
                bit_last_out  = last_mod;
                if (bit_ready_in) state_d = last_mod ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done_out = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: accumulators, counters, address and sample registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pitch_q  <= '0;
            ax0_q    <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            oob_q    <= 1'b0;
            sample_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef SAMPLER_MAJORITY_EN
            tap_q    <= '0;
            ones_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        pitch_q <= pitch_in;
                        ax0_q   <= x_start;
                        ax_q    <= x_start;
                        ay_q    <= y_start;
                        row_q   <= '0;
                        col_q   <= '0;
                        error_q <= 1'b0;
`ifdef SAMPLER_MAJORITY_EN
                        tap_q   <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    addr_q <= in_bounds ? rd_addr : '0;
                    oob_q  <= !in_bounds;
                    if (!in_bounds) error_q <= 1'b1;
                end
                S_WAIT_TWO: begin
`ifdef SAMPLER_MAJORITY_EN
                    if (tap_q == 2'd2) begin
                        sample_q <= !oob_q && ((ones_q + {1'b0, BRAM_one_data}) >= 2'd2);
                        tap_q    <= '0;
                    end else begin
                        ones_q <= (tap_q == 2'd0) ? {1'b0, BRAM_one_data}
                                                  : ones_q + {1'b0, BRAM_one_data};
                        tap_q  <= tap_q + 2'd1;
                    end
`else
                    sample_q <= !oob_q && BRAM_one_data;
`endif
                end
                S_OUTPUT: begin
                    if (bit_ready_in) begin
                        if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            ax_q  <= ax0_q;
                            ay_q  <= sat_add(ay_q, pitch_q);
                        end else begin
                            col_q <= col_q + 1'b1;
                            ax_q  <= sat_add(ax_q, pitch_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BRAM_one_address = addr_q;
    assign bit_out          = sample_q;
    assign error_out        = error_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_module_grid_sampler.sv
`timescale 1ns/1ps
module tb_module_grid_sampler;
  localparam int W  = 480;
  localparam int H  = 480;
  localparam int G  = 21;
  localparam int N  = G * G;
  localparam int AW = 19;
`ifdef SAMPLER_MAJORITY_EN
  localparam int MAJ = 1;
  localparam int CYC = 10;
`else
  localparam int MAJ = 0;
  localparam int CYC = 4;
`endif
  localparam int P_ONES  = 0;
  localparam int P_CHECK = 1;
  localparam int P_DOT   = 2;
  localparam int P_RAND  = 3;

  // ---------------- clock / reset / dut ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    ox_i = '0;
  logic [8:0]    oy_i = '0;
  logic [11:0]   pitch_i = '0;
  logic [AW-1:0] addr;
  logic          bram_data;
  logic          bit_o, valid, last, busy, done, err;
  logic          ready = 1'b0;
  logic [2:0]    dbg;

  always #5 clk = ~clk;

  module_grid_sampler #(.WIDTH(W), .HEIGHT(H), .GRID(G), .ADDR_W(AW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .origin_x_in(ox_i), .origin_y_in(oy_i), .pitch_in(pitch_i),
    .BRAM_one_address(addr), .BRAM_one_data(bram_data),
    .bit_out(bit_o), .bit_valid_out(valid), .bit_ready_in(ready),
    .bit_last_out(last), .busy_out(busy), .done_out(done),
    .error_out(err), .dbg_state_o(dbg)
  );

  // Bitmap memory: one register stage after the DUT's registered address.
  bit   mem [W*H];
  logic bram_q = 1'b0;
  always @(posedge clk) bram_q <= mem[addr];
  assign bram_data = bram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int   total = 0;
  int   bad = 0;
  logic exp_q[$];
  int   bit_idx = 0, ones_cnt = 0, done_cnt = 0, last_cyc = 0;
  bit   prev_stall = 0, prev_bit = 0, prev_last = 0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = (cyc % 3 == 0);
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", valid, 1);
        check("hold_bit", bit_o, prev_bit);
        check("hold_last", last, prev_last);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_bit: got bit index %0d, required at most %0d bits", bit_idx, N);
        end else begin
          logic e;
          e = exp_q.pop_front();
          check("bit", bit_o, e);
          check("last", last, (bit_idx == N - 1));
          if (ready_mode == 0 && bit_idx > 0) check("spacing", cyc - last_cyc, CYC);
        end
        if (bit_o) ones_cnt++;
        last_cyc = cyc;
        bit_idx++;
      end
      prev_stall = valid && !ready;
      prev_bit   = bit_o;
      prev_last  = last;
    end else begin
      prev_stall = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_mem(input int pat);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (pat)
          P_ONES:  mem[y*W + x] = 1'b1;
          P_CHECK: mem[y*W + x] = 1'(((x / 16) + (y / 16)) % 2);
          P_DOT:   mem[y*W + x] = !((x % 16 == 8) && (y % 16 == 8));
          default: mem[y*W + x] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  // Reference: sample positions from plain arithmetic on the latched parameters.
  task automatic build_model(input int ox, input int oy, input int pitch,
                             output int first, output bit exp_err);
    exp_q.delete();
    exp_err = 0;
    first = 0;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        int  xq, yq, px, py, a, s;
        logic b;
        xq = ox * 16 + pitch / 2 + c * pitch;
        yq = oy * 16 + pitch / 2 + r * pitch;
        if (xq > 8191) xq = 8191;
        if (yq > 8191) yq = 8191;
        px = xq / 16;
        py = yq / 16;
        if (xq == 8191 || yq == 8191 || px >= W || py >= H) begin
          exp_err = 1;
          b = 1'b0;
          a = 0;
        end else if (MAJ != 0) begin
          int l, rr;
          l  = (px > 0) ? px - 1 : 0;
          rr = (px < W - 1) ? px + 1 : W - 1;
          s  = int'(mem[py*W + l]) + int'(mem[py*W + px]) + int'(mem[py*W + rr]);
          b  = (s >= 2);
          a  = py * W + l;
        end else begin
          b = mem[py*W + px];
          a = py * W + px;
        end
        if (r == 0 && c == 0) first = a;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_frame(input int ox, input int oy, input int pitch, input int rmode);
    bit_idx = 0; ones_cnt = 0; done_cnt = 0; prev_stall = 0; ready_mode = rmode;
    @(posedge clk);
    #1;
    start = 1'b1; ox_i = ox[8:0]; oy_i = oy[8:0]; pitch_i = pitch[11:0];
    @(posedge clk);
    #1;
    // Scramble the inputs to show that they were latched.
    start = 1'b0; ox_i = 9'($urandom); oy_i = 9'($urandom); pitch_i = 12'($urandom);
  endtask

  task automatic run_frame(input int ox, input int oy, input int pitch, input int rmode,
                           input bit poke, output int first_seen, output int ones_seen);
    int exp_first;
    bit exp_err, got_done, poked;
    build_model(ox, oy, pitch, exp_first, exp_err);
    start_frame(ox, oy, pitch, rmode);
    @(negedge clk);
    check("busy_on", busy, 1);
    @(negedge clk);
    first_seen = int'(addr);
    check("first_addr", addr, exp_first);
    got_done = 0;
    poked = 0;
    for (int i = 0; i < 30000 && !got_done; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        start = 1'b0;
      end else if (poke && !poked && bit_idx >= 50) begin
        start = 1'b1;   // must be ignored while busy
        poked = 1;
      end else begin
        start = 1'b0;
      end
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d bits and no done, required %0d bits and done", bit_idx, N);
      reset_dut();
    end else begin
      check("busy_at_done", busy, 0);
      check("err_at_done", err, exp_err);
      check("bits_at_done", bit_idx, N);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("done_count", done_cnt, 1);
      check("exp_q_empty", exp_q.size(), 0);
      check("err_sticky", err, exp_err);
      check("idle_valid", valid, 0);
    end
    ones_seen = ones_cnt;
  endtask

  // ---------------- table-driven frames ----------------
  typedef struct {
    int ox, oy, pitch, pat, rmode;
    int exp_first, exp_err, exp_ones;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   fa, on, ef;
    bit   eb;

    vecs[0] = '{0,   0,   256, P_ONES,  0, 3848 - MAJ,   0, 441};
    vecs[1] = '{0,   0,   256, P_CHECK, 0, 3848 - MAJ,   0, 220};
    vecs[2] = '{400, 400, 256, P_ONES,  0, 196248 - MAJ, 1, 25};
    vecs[3] = '{0,   0,   256, P_CHECK, 1, 3848 - MAJ,   0, 220};
    vecs[4] = '{0,   0,   256, P_DOT,   0, 3848 - MAJ,   0, MAJ * 441};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_last", last, 0);
    check("rst_bit", bit_o, 0);
    check("rst_addr", addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    for (int v = 0; v < 5; v++) begin
      fill_mem(vecs[v].pat);
      run_frame(vecs[v].ox, vecs[v].oy, vecs[v].pitch, vecs[v].rmode, 1'b0, fa, on);
      check("tbl_first", fa, vecs[v].exp_first);
      check("tbl_ones", on, vecs[v].exp_ones);
      check("tbl_err", err, vecs[v].exp_err);
    end

    // Mid-frame reset (row 5) during an out-of-image frame, then a clean frame
    fill_mem(P_ONES);
    build_model(400, 400, 256, ef, eb);
    start_frame(400, 400, 256, 0);
    for (int i = 0; i < 5000 && bit_idx < 110; i++) @(negedge clk);
    check("abort_reached", (bit_idx >= 110), 1);
    check("err_before_abort", err, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_err", err, 0);
    check("abort_addr", addr, 0);
    check("abort_last", last, 0);
    check("abort_bit", bit_o, 0);
    exp_q.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_frame(0, 0, 256, 0, 1'b0, fa, on);
    check("after_abort_ones", on, 441);

    // Randomized frames; the first one also pulses start while busy
    for (int k = 0; k < 3; k++) begin
      int ox, oy, pitch;
      fill_mem(P_RAND);
      ox    = (k == 2) ? $urandom_range(300, 479) : $urandom_range(0, 200);
      oy    = $urandom_range(0, 200);
      pitch = $urandom_range(96, 400);
      run_frame(ox, oy, pitch, 2, (k == 0), fa, on);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
